uart_receiver: RTL and testbench

UART receive path that pairs with the team's existing 8N1 UART transmitter. Takes the asynchronous serial line, synchronises it, and finds the start bit. Samples each bit at mid-bit and presents the received byte on a valid/ready output. Sits between the FPGA rx pin and the byte-consuming logic (FIFO, command decoder, loopback path).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_receiver_if.sv | 31 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_receiver.sv | 164 ++++++++++++++++
 tb/tb_uart_receiver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing definitions used by both the transmitter and the receiver.
package uart_pkg;

  // 8N1 framing: eight data bits, LSB first, no parity, one stop bit.
  localparam int UART_DATA_BITS = 8;

  // 9600 baud at a 50 MHz system clock.
  localparam int DEFAULT_CLOCKS_PER_PULSE = 5208;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Byte stream leaving the UART receiver: valid/ready handshake plus status pulses.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      rx_busy;

  // The receiver produces bytes and status; the consumer only drives ready.
  modport master (
    output data_out,
    output out_valid,
    output frame_err,
    output overrun,
    output rx_busy,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    input  frame_err,
    input  overrun,
    input  rx_busy,
    output out_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage shift; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep both stages sampling the pre-edge values,
    // so the data really takes two clocks to pass through.
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises rx, qualifies the start bit at half a bit period,
// samples each data bit and the stop bit at mid-bit, and presents bytes on valid/ready.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  uart_receiver_if.master rx_if
);

  localparam int HALF_PULSE = CLOCKS_PER_PULSE / 2;
  localparam int CNT_W      = $clog2(CLOCKS_PER_PULSE);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PULSE - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_e                 state_q,     state_d;
  logic [CNT_W-1:0]          c_clocks_q,  c_clocks_d;
  logic [2:0]                c_bits_q,    c_bits_d;
  logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
  logic [UART_DATA_BITS-1:0] data_q,      data_d;
  logic                      valid_q,     valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q,   overrun_d;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // State, counters and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      c_clocks_q  <= '0;
      c_bits_q    <= '0;
      // NOTE: the shift register is reset too, so a frame aborted by reset
      // leaves nothing behind that could leak into a later byte.
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_clocks_q  <= c_clocks_d;
      c_bits_q    <= c_bits_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, bit sampling and output handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no branch
    // can leave one unassigned and infer a latch.
    state_d     = state_q;
    c_clocks_d  = c_clocks_q;
    c_bits_d    = c_bits_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer takes the held byte; may be overridden below by a new byte.
    if (valid_q && rx_if.out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d    = RX_START;
          c_clocks_d = '0;
        end
      end

      // Still low at mid start bit means a real start, not a glitch.
      RX_START: begin
        if (c_clocks_q == HALF_LAST) begin
          c_clocks_d = '0;
          if (!rx_s) begin
            state_d  = RX_DATA;
            c_bits_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          c_clocks_d = c_clocks_q + CNT_W'(1);
        end
      end

      // Sampling a full period after mid start lands in the middle of each data bit.
      RX_DATA: begin
        if (c_clocks_q == BIT_LAST) begin
          c_clocks_d        = '0;
          shift_d[c_bits_q] = rx_s;
          if (c_bits_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            c_bits_d = c_bits_q + 3'd1;
          end
        end else begin
          c_clocks_d = c_clocks_q + CNT_W'(1);
        end
      end

      RX_STOP: begin
        if (c_clocks_q == BIT_LAST) begin
          c_clocks_d = '0;
          if (rx_s) begin
            state_d = RX_IDLE;
            // The output slot is free if empty or being emptied this very cycle.
            if (!valid_q || rx_if.out_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          c_clocks_d = c_clocks_q + CNT_W'(1);
        end
      end

      // A held-low line must return high before another start bit is looked for.
      RX_BREAK: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_if.data_out  = data_q;
  assign rx_if.out_valid = valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.rx_busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: bit-accurate serialiser, table of single
// frames, hand-written handshake/reset corner cases and a randomised frame stream.
module tb_uart_receiver;

  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 9 * C + H + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_receiver_if u_if ();

  uart_receiver #(
    .CLOCKS_PER_PULSE (C)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state, written only by the monitor process.
  int         cyc       = 0;
  int         rise_cyc  = -1;
  int         n_ferr    = 0;
  int         n_ovr     = 0;
  int         n_viol    = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] got_q[$];

  // Written only by the serialiser.
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Collects handshakes and status pulses; also watches data stability while held.
  always @(negedge clk) begin
    if (u_if.frame_err) n_ferr <= n_ferr + 1;
    if (u_if.overrun)   n_ovr  <= n_ovr + 1;
    if (u_if.out_valid && !prev_valid) rise_cyc <= cyc;
    if (u_if.out_valid && prev_valid && !prev_ready && u_if.data_out != prev_data)
      n_viol <= n_viol + 1;
    if (u_if.out_valid && u_if.out_ready) got_q.push_back(u_if.data_out);
    prev_valid <= u_if.out_valid;
    prev_ready <= u_if.out_ready;
    prev_data  <= u_if.data_out;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         low_extra;
    int         exp_bytes;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    wait_cycles(n);
  endtask

  // Start bit, 8 data bits LSB first, stop bit (or a held-low line), then idle gap.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                            input int low_extra, input int gap);
    start_cyc = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(b[i], C);
    if (stop_ok) hold(1'b1, C);
    else         hold(1'b0, C + low_extra);
    hold(1'b1, gap);
  endtask

  function automatic logic [7:0] last_got();
    logic [7:0] v;
    v = 'x;
    if (got_q.size() > 0) v = got_q[got_q.size()-1];
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         ferr0;
    int         ovr0;
    logic [7:0] exp_q[$];
    int         exp_ferr;

    vecs[0] = '{8'h00, 1'b1, 0,  1, 8'h00, 0};
    vecs[1] = '{8'hFF, 1'b1, 0,  1, 8'hFF, 0};
    vecs[2] = '{8'h3C, 1'b0, 40, 0, 8'h00, 1};
    vecs[3] = '{8'h81, 1'b1, 0,  1, 8'h81, 0};
    vecs[4] = '{8'h01, 1'b1, 0,  1, 8'h01, 0};
    vecs[5] = '{8'h80, 1'b1, 0,  1, 8'h80, 0};

    u_if.out_ready = 1'b1;
    rst = 1'b1;
    wait_cycles(3);
    check("reset_data",  {24'd0, u_if.data_out}, 32'h00);
    check("reset_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("reset_ferr",  {31'd0, u_if.frame_err}, 32'd0);
    check("reset_ovr",   {31'd0, u_if.overrun},   32'd0);
    check("reset_busy",  {31'd0, u_if.rx_busy},   32'd0);
    rst = 1'b0;
    wait_cycles(5);
    check("idle_after_reset_busy", {31'd0, u_if.rx_busy}, 32'd0);

    // 0xA5 with latency measurement.
    base = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
    send_frame(8'hA5, 1'b1, 0, 4);
    check("a5_count", got_q.size() - base, 1);
    check("a5_data", {24'd0, last_got()}, 32'hA5);
    check("a5_ferr", n_ferr - ferr0, 0);
    check("a5_ovr", n_ovr - ovr0, 0);
    check_range("a5_latency", rise_cyc - start_cyc, LAT - 1, LAT + 1);

    // Start glitch: four cycles low, then back high.
    base = got_q.size();
    rx = 1'b0;
    wait_cycles(4);
    check("glitch_busy_high", {31'd0, u_if.rx_busy}, 32'd1);
    rx = 1'b1;
    wait_cycles(H + 3);
    check("glitch_busy_low", {31'd0, u_if.rx_busy}, 32'd0);
    wait_cycles(C);
    check("glitch_no_byte", got_q.size() - base, 0);
    check("glitch_valid", {31'd0, u_if.out_valid}, 32'd0);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      base = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].low_extra, 6);
      check($sformatf("vec%0d_count", i), got_q.size() - base, vecs[i].exp_bytes);
      if (vecs[i].exp_bytes > 0)
        check($sformatf("vec%0d_data", i), {24'd0, last_got()}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_ferr", i), n_ferr - ferr0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), n_ovr - ovr0, 0);
      check($sformatf("vec%0d_busy", i), {31'd0, u_if.rx_busy}, 32'd0);
    end

    // Overrun: consumer stalled, two back-to-back bytes.
    base = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
    u_if.out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 0, 4);
    check("ovr_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("ovr_data_held", {24'd0, u_if.data_out}, 32'h11);
    check("ovr_pulses", n_ovr - ovr0, 1);
    check("ovr_ferr", n_ferr - ferr0, 0);
    check("ovr_stable", n_viol, 0);
    u_if.out_ready = 1'b1;
    wait_cycles(1);
    check("ovr_drain_valid", {31'd0, u_if.out_valid}, 32'd0);
    wait_cycles(4);
    check("ovr_drain_count", got_q.size() - base, 1);
    check("ovr_drain_data", {24'd0, last_got()}, 32'h11);

    // Consume in exactly the cycle the next byte completes.
    base = got_q.size(); ovr0 = n_ovr;
    u_if.out_ready = 1'b0;
    send_frame(8'h33, 1'b1, 0, 2);
    check("simul_first_held", {24'd0, u_if.data_out}, 32'h33);
    fork
      send_frame(8'h44, 1'b1, 0, 4);
      begin
        wait_cycles(LAT - 1);
        u_if.out_ready = 1'b1;
        wait_cycles(1);
        u_if.out_ready = 1'b0;
        check("simul_next_valid", {31'd0, u_if.out_valid}, 32'd1);
        check("simul_next_data", {24'd0, u_if.data_out}, 32'h44);
      end
    join
    check("simul_no_ovr", n_ovr - ovr0, 0);
    check("simul_first_taken", {24'd0, last_got()}, 32'h33);
    u_if.out_ready = 1'b1;
    wait_cycles(2);
    check("simul_count", got_q.size() - base, 2);
    check("simul_second_taken", {24'd0, last_got()}, 32'h44);

    // Reset in the middle of the data bits of 0xFF.
    base = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
    fork
      send_frame(8'hFF, 1'b1, 0, 4);
      begin
        wait_cycles(3 + H + 3 * C);
        check("rst_mid_busy_before", {31'd0, u_if.rx_busy}, 32'd1);
        rst = 1'b1;
        wait_cycles(1);
        check("rst_mid_data",  {24'd0, u_if.data_out}, 32'h00);
        check("rst_mid_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("rst_mid_busy",  {31'd0, u_if.rx_busy}, 32'd0);
        check("rst_mid_ferr",  {31'd0, u_if.frame_err}, 32'd0);
        check("rst_mid_ovr",   {31'd0, u_if.overrun}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
      end
    join
    wait_cycles(C);
    check("rst_no_partial", got_q.size() - base, 0);
    check("rst_no_ferr", n_ferr - ferr0, 0);
    send_frame(8'h5A, 1'b1, 0, 4);
    check("rst_after_count", got_q.size() - base, 1);
    check("rst_after_data", {24'd0, last_got()}, 32'h5A);
    check("rst_after_ovr", n_ovr - ovr0, 0);

    // Randomised stream against a queue model: good stop delivers, bad stop flags.
    base = got_q.size(); ferr0 = n_ferr; ovr0 = n_ovr;
    exp_ferr = 0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      if (ok) begin
        exp_q.push_back(b);
        send_frame(b, 1'b1, 0, $urandom_range(0, 12));
      end else begin
        exp_ferr++;
        send_frame(b, 1'b0, $urandom_range(0, 30), $urandom_range(2, 12));
      end
    end
    wait_cycles(2 * C);
    check("rand_count", got_q.size() - base, exp_q.size());
    check("rand_ferr", n_ferr - ferr0, exp_ferr);
    check("rand_ovr", n_ovr - ovr0, 0);
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      check($sformatf("rand_byte%0d", i), {24'd0, got_q[base+i]}, {24'd0, exp_q[i]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
